// File: rtl/hs_bus_amba_axis_sif2w_rs_if.sv
// ---------------------------------------------------------------------------
// hs_bus_amba_axis_if
//
// Purpose
//   AXI4-Stream bundle shared by the hs_bus AMBA adapters. One instance
//   carries one stream between a master and a slave.
//
// Signals
//   tvalid / tready   handshake pair (tready driven by the slave)
//   tdata             payload, TDATA_WIDTH bits
//   tstrb / tkeep     per-byte strobe and keep
//   tlast             packet end marker
//   tid / tdest       stream ID and routing destination
//   tuser             user sideband
//   twakeup           wakeup hint from the master
//
// Modports
//   master            drives everything except tready
//   slave             drives tready, observes everything else
// ---------------------------------------------------------------------------
interface hs_bus_amba_axis_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8
);

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TSTRB_WIDTH-1:0] tstrb;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   twakeup;

    modport master (
        output tvalid,
        input  tready,
        output tdata,
        output tstrb,
        output tkeep,
        output tlast,
        output tid,
        output tdest,
        output tuser,
        output twakeup
    );

    modport slave (
        input  tvalid,
        output tready,
        input  tdata,
        input  tstrb,
        input  tkeep,
        input  tlast,
        input  tid,
        input  tdest,
        input  tuser,
        input  twakeup
    );

endinterface

// File: rtl/hs_bus_amba_axis_sif2w_rs.sv
// ---------------------------------------------------------------------------
// hs_bus_amba_axis_sif2w_rs
//
// Purpose
//   Terminates an hs_bus_amba_axis_if slave modport and re-drives the stream
//   on discrete m_axis_* wires through a full register slice (main register
//   plus one skid register). Every output, including the upstream tready,
//   comes straight from a flop, so timing is cut in both directions while
//   still sustaining one beat per cycle. Beat/packet counters and an
//   in-packet flag are provided for status registers.
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   s_axis_if         upstream stream (slave side)
//   m_axis_*          downstream stream; m_axis_tready is the only input
//   m_axis_twakeup    registered wakeup (upstream wakeup or data held here)
//   beat_cnt          downstream handshakes since reset, wraps
//   pkt_cnt           downstream handshakes carrying tlast, wraps
//   in_pkt            a packet has started downstream but not yet ended
// ---------------------------------------------------------------------------
module hs_bus_amba_axis_sif2w_rs #(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hs_bus_amba_axis_if.slave      s_axis_if,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TSTRB_WIDTH-1:0] m_axis_tstrb,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [TID_WIDTH-1:0]   m_axis_tid,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_twakeup,
    output logic [CNT_WIDTH-1:0]   beat_cnt,
    output logic [CNT_WIDTH-1:0]   pkt_cnt,
    output logic                   in_pkt
);

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic [TSTRB_WIDTH-1:0] tstrb;
        logic [TKEEP_WIDTH-1:0] tkeep;
        logic                   tlast;
        logic [TID_WIDTH-1:0]   tid;
        logic [TDEST_WIDTH-1:0] tdest;
        logic [TUSER_WIDTH-1:0] tuser;
    } beat_t;

    // State encoding is literally {main_v, skid_v}, so the valid bits are
    // just the two state bits and never need separate flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t               state_q;
    beat_t                main_q;
    beat_t                skid_q;
    beat_t                s_beat;
    logic                 tready_q;
    logic                 twakeup_q;
    logic                 main_v;
    logic                 skid_v;
    logic                 acc_in;
    logic                 acc_out;
    logic [CNT_WIDTH-1:0] beat_cnt_q;
    logic [CNT_WIDTH-1:0] beat_cnt_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q;
    logic [CNT_WIDTH-1:0] pkt_cnt_d;
    logic                 in_pkt_q;
    logic                 in_pkt_d;

    assign main_v = state_q[1];
    assign skid_v = state_q[0];

    assign s_beat = '{
        tdata: s_axis_if.tdata,
        tstrb: s_axis_if.tstrb,
        tkeep: s_axis_if.tkeep,
        tlast: s_axis_if.tlast,
        tid:   s_axis_if.tid,
        tdest: s_axis_if.tdest,
        tuser: s_axis_if.tuser
    };

    // Handshakes use only registered ready/valid, so neither side sees a
    // combinational path through this block.
    assign acc_in  = s_axis_if.tvalid & tready_q;
    assign acc_out = main_v & m_axis_tready;

    // Register-slice FSM. The main register always holds the oldest beat and
    // drives the outputs; the skid register only catches the one beat that
    // arrives in the same cycle the downstream stalls, which is possible
    // because upstream sees our ready one cycle late. tready is the inverse
    // of the next skid-valid, so it drops exactly when the skid fills and
    // returns the cycle the skid drains into main.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
            unique case (state_q)
                EMPTY: begin
                    if (acc_in) begin
                        main_q  <= s_beat;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (acc_in && acc_out) begin
                        main_q <= s_beat;
                    end else if (acc_in) begin
                        skid_q   <= s_beat;
                        state_q  <= FULL;
                        tready_q <= 1'b0;
                    end else if (acc_out) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (acc_out) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end else begin
                        tready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    // Status next-state: counters advance on each downstream handshake and
    // wrap naturally at the counter width; in_pkt follows the tlast of the
    // beat just sent.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        in_pkt_d   = in_pkt_q;
        if (acc_out) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
            in_pkt_d   = ~main_q.tlast;
            if (main_q.tlast) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Status and wakeup registers. Wakeup stays asserted while either
    // storage register holds data so downstream is not allowed to sleep
    // with a beat still parked here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            in_pkt_q   <= 1'b0;
            twakeup_q  <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            in_pkt_q   <= in_pkt_d;
            twakeup_q  <= s_axis_if.twakeup | main_v | skid_v;
        end
    end

    assign s_axis_if.tready = tready_q;

    assign m_axis_tvalid  = main_v;
    assign m_axis_tdata   = main_q.tdata;
    assign m_axis_tstrb   = main_q.tstrb;
    assign m_axis_tkeep   = main_q.tkeep;
    assign m_axis_tlast   = main_q.tlast;
    assign m_axis_tid     = main_q.tid;
    assign m_axis_tdest   = main_q.tdest;
    assign m_axis_tuser   = main_q.tuser;
    assign m_axis_twakeup = twakeup_q;

    assign beat_cnt = beat_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign in_pkt   = in_pkt_q;

endmodule

// File: tb/tb_hs_bus_amba_axis_sif2w_rs.sv
module tb_hs_bus_amba_axis_sif2w_rs;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tstrb;
        logic       tkeep;
        logic       tlast;
        logic       tid;
        logic       tdest;
        logic       tuser;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) sif();
    hs_bus_amba_axis_if #(.TDATA_WIDTH(8)) sif4();

    logic        m_tvalid, m_tready, m_tlast, m_tid, m_tdest, m_tuser, m_twakeup;
    logic [7:0]  m_tdata;
    logic        m_tstrb, m_tkeep;
    logic [31:0] beat_cnt, pkt_cnt;
    logic        in_pkt;

    logic        m4_tvalid, m4_tlast, m4_tid, m4_tdest, m4_tuser, m4_twakeup;
    logic        m4_tready = 1'b1;
    logic [7:0]  m4_tdata;
    logic        m4_tstrb, m4_tkeep;
    logic [3:0]  beat_cnt4, pkt_cnt4;
    logic        in_pkt4;

    hs_bus_amba_axis_sif2w_rs #(.TDATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .s_axis_if(sif.slave),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tid(m_tid), .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser), .m_axis_twakeup(m_twakeup),
        .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt), .in_pkt(in_pkt)
    );

    hs_bus_amba_axis_sif2w_rs #(.TDATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .s_axis_if(sif4.slave),
        .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready),
        .m_axis_tdata(m4_tdata), .m_axis_tstrb(m4_tstrb), .m_axis_tkeep(m4_tkeep),
        .m_axis_tlast(m4_tlast), .m_axis_tid(m4_tid), .m_axis_tdest(m4_tdest),
        .m_axis_tuser(m4_tuser), .m_axis_twakeup(m4_twakeup),
        .beat_cnt(beat_cnt4), .pkt_cnt(pkt_cnt4), .in_pkt(in_pkt4)
    );

    int          nChecks = 0;
    int          nErrors = 0;
    beat_t       sbQueue[$];
    int          pushCnt = 0;
    bit          monEn = 1'b0;
    bit          prevStall = 1'b0;
    beat_t       prevBeat;
    logic [31:0] expBeatCnt = '0;
    logic [31:0] expPktCnt = '0;
    logic        expInPkt = 1'b0;

    function automatic beat_t inBeat();
        return {sif.tdata, sif.tstrb, sif.tkeep, sif.tlast, sif.tid, sif.tdest, sif.tuser};
    endfunction

    function automatic beat_t outBeat();
        return {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one upstream beat; sideband bits are derived from the data so
    // that every field is exercised by the scoreboard.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic last);
        sif.tvalid  = v;
        sif.tdata   = d;
        sif.tstrb   = ~d[3];
        sif.tkeep   = d[4];
        sif.tlast   = last;
        sif.tid     = d[0];
        sif.tdest   = d[1];
        sif.tuser   = d[2];
        sif.twakeup = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge where everything is
    // stable. Accepted input beats are queued; each output handshake pops
    // and compares the oldest one. A reference model of the counters and
    // in_pkt is checked every cycle, and a stalled output must not change.
    always @(negedge clk) begin
        if (monEn) begin
            beat_t exp;
            checkOutput("beat_cnt", 64'(beat_cnt), 64'(expBeatCnt));
            checkOutput("pkt_cnt", 64'(pkt_cnt), 64'(expPktCnt));
            checkOutput("in_pkt", 64'(in_pkt), 64'(expInPkt));
            if (prevStall) begin
                checkOutput("stall_valid", 64'(m_tvalid), 64'd1);
                checkOutput("stall_payload", 64'(outBeat()), 64'(prevBeat));
            end
            if (m_tvalid && m_tready) begin
                checkOutput("sb_pop_avail", 64'(sbQueue.size() > 0), 64'd1);
                if (sbQueue.size() > 0) begin
                    exp = sbQueue.pop_front();
                    checkOutput("sb_beat", 64'(outBeat()), 64'(exp));
                    expBeatCnt = expBeatCnt + 32'd1;
                    if (exp.tlast) expPktCnt = expPktCnt + 32'd1;
                    expInPkt = ~exp.tlast;
                end
            end
            prevStall = m_tvalid && !m_tready;
            prevBeat  = outBeat();
            if (sif.tvalid && sif.tready) begin
                sbQueue.push_back(inBeat());
                pushCnt++;
            end
        end
    end

    // Directed test sequence followed by the random soak.
    initial begin
        int base;
        int sent;
        int cyc;
        bit acc;

        applyStimulus(1'b0, 8'h00, 1'b0);
        m_tready     = 1'b0;
        sif4.tvalid  = 1'b0;
        sif4.tdata   = '0;
        sif4.tstrb   = '0;
        sif4.tkeep   = '0;
        sif4.tlast   = 1'b0;
        sif4.tid     = '0;
        sif4.tdest   = '0;
        sif4.tuser   = '0;
        sif4.twakeup = 1'b0;

        // Power-on reset
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rst_tready", 64'(sif.tready), 64'd0);
        checkOutput("rst_tdata", 64'(m_tdata), 64'd0);
        checkOutput("rst_twakeup", 64'(m_twakeup), 64'd0);
        checkOutput("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rel_tready_before_edge", 64'(sif.tready), 64'd0);
        @(posedge clk); #1;
        checkOutput("rel_tready_after_edge", 64'(sif.tready), 64'd1);
        monEn = 1'b1;

        // Counter wrap on the 4-bit instance: 17 single-beat packets
        for (int i = 0; i < 17; i++) begin
            sif4.tvalid = 1'b1;
            sif4.tdata  = 8'(i);
            sif4.tlast  = 1'b1;
            @(negedge clk);
            checkOutput("t5_tready", 64'(sif4.tready), 64'd1);
            @(posedge clk); #1;
        end
        sif4.tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t5_beat_cnt_wrap", 64'(beat_cnt4), 64'd1);
        checkOutput("t5_pkt_cnt_wrap", 64'(pkt_cnt4), 64'd1);
        checkOutput("t5_in_pkt", 64'(in_pkt4), 64'd0);

        // Streaming: 16 beats back to back with downstream always ready
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i), i == 15);
            @(negedge clk);
            checkOutput("t2_tready", 64'(sif.tready), 64'd1);
            if (i > 0) begin
                checkOutput("t2_tvalid", 64'(m_tvalid), 64'd1);
                checkOutput("t2_latency_data", 64'(m_tdata), 64'(i - 1));
            end
            @(posedge clk); #1;
        end
        sif.tvalid = 1'b0;
        @(negedge clk);
        checkOutput("t2_last_data", 64'(m_tdata), 64'h0F);
        checkOutput("t2_last_tlast", 64'(m_tlast), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t2_drained", 64'(m_tvalid), 64'd0);
        checkOutput("t2_beat_cnt", 64'(beat_cnt), 64'd16);
        checkOutput("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Backpressure: three beats offered while downstream stalls
        @(posedge clk); #1;
        m_tready = 1'b0;
        base = pushCnt;
        applyStimulus(1'b1, 8'hA0, 1'b0);
        @(negedge clk);
        checkOutput("t3_tready_b0", 64'(sif.tready), 64'd1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'hA1, 1'b0);
        @(negedge clk);
        checkOutput("t3_tready_b1", 64'(sif.tready), 64'd1);
        checkOutput("t3_hold_b0", 64'(m_tdata), 64'hA0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'hA2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t3_tready_full", 64'(sif.tready), 64'd0);
            checkOutput("t3_hold_data", 64'(m_tdata), 64'hA0);
            checkOutput("t3_twakeup", 64'(m_twakeup), 64'd1);
            @(posedge clk); #1;
            checkOutput("t3_accepted", 64'(pushCnt - base), 64'd2);
        end
        m_tready = 1'b1;
        @(negedge clk);
        checkOutput("t3_out0", 64'(m_tdata), 64'hA0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3_out1", 64'(m_tdata), 64'hA1);
        checkOutput("t3_tready_back", 64'(sif.tready), 64'd1);
        @(posedge clk); #1;
        sif.tvalid = 1'b0;
        @(negedge clk);
        checkOutput("t3_out2", 64'(m_tdata), 64'hA2);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t3_empty", 64'(m_tvalid), 64'd0);

        // in_pkt tracking over a 3-beat packet
        @(posedge clk); #1;
        checkOutput("t6_in_pkt_idle", 64'(in_pkt), 64'd0);
        applyStimulus(1'b1, 8'h50, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h51, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h52, 1'b1);
        @(negedge clk);
        checkOutput("t6_in_pkt_b0", 64'(in_pkt), 64'd1);
        @(posedge clk); #1;
        sif.tvalid = 1'b0;
        @(negedge clk);
        checkOutput("t6_in_pkt_b1", 64'(in_pkt), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t6_in_pkt_b2", 64'(in_pkt), 64'd0);
        @(posedge clk); #1;

        // Random valid/ready soak; valid is held until accepted
        sent = 0;
        cyc  = 0;
        acc  = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!sif.tvalid || acc) begin
                sif.tvalid  = 1'($urandom_range(1));
                sif.tdata   = 8'($urandom);
                sif.tstrb   = 1'($urandom);
                sif.tkeep   = 1'($urandom);
                sif.tlast   = 1'($urandom);
                sif.tid     = 1'($urandom);
                sif.tdest   = 1'($urandom);
                sif.tuser   = 1'($urandom);
                sif.twakeup = 1'($urandom);
            end
            m_tready = 1'($urandom_range(1));
            @(negedge clk);
            acc = sif.tvalid && sif.tready;
            if (acc) sent++;
            cyc++;
            @(posedge clk); #1;
        end
        sif.tvalid  = 1'b0;
        sif.twakeup = 1'b0;
        checkOutput("t4_budget", 64'(sent), 64'd10000);
        m_tready = 1'b1;
        for (int k = 0; k < 20 && (sbQueue.size() > 0 || m_tvalid); k++) begin
            @(posedge clk); #1;
        end
        checkOutput("t4_drain", 64'(sbQueue.size()), 64'd0);
        checkOutput("t4_beat_total", 64'(beat_cnt), 64'(expBeatCnt));

        // Reset while FULL
        m_tready = 1'b0;
        applyStimulus(1'b1, 8'hC0, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'hC1, 1'b0);
        @(posedge clk); #1;
        sif.tvalid = 1'b0;
        @(negedge clk);
        checkOutput("t1_full_tready", 64'(sif.tready), 64'd0);
        checkOutput("t1_full_tvalid", 64'(m_tvalid), 64'd1);
        monEn = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("t1_tvalid", 64'(m_tvalid), 64'd0);
        checkOutput("t1_tready", 64'(sif.tready), 64'd0);
        checkOutput("t1_tdata", 64'(m_tdata), 64'd0);
        checkOutput("t1_beat_cnt", 64'(beat_cnt), 64'd0);
        checkOutput("t1_pkt_cnt", 64'(pkt_cnt), 64'd0);
        checkOutput("t1_in_pkt", 64'(in_pkt), 64'd0);
        checkOutput("t1_twakeup", 64'(m_twakeup), 64'd0);
        sbQueue.delete();
        expBeatCnt = '0;
        expPktCnt  = '0;
        expInPkt   = 1'b0;
        prevStall  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t1_tready_held", 64'(sif.tready), 64'd0);
        @(posedge clk); #1;
        checkOutput("t1_tready_rise", 64'(sif.tready), 64'd1);
        checkOutput("t1_discarded", 64'(m_tvalid), 64'd0);
        monEn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
